uart_rx_framed: RTL and testbench
=================================

// Module: uart_rx_framed
// PURPOSE
//   Parametrised UART receiver, successor to the fixed 8N1 receiver. Configurable data width,
//   parity and stop bits; reports parity/framing errors and overrun; holds each received word
//   under a valid/ack handshake. Sits between the external RX pin and the sensor command decoder.
// PARAMETERS
//   CLOCKS_PER_BIT  87  clock cycles per bit (10 MHz / 115200 + 1); minimum 8
//   DATA_BITS       8   data bits per frame, 5..9, LSB first
//   PARITY_MODE     0   0 = none, 1 = odd, 2 = even
//   STOP_BITS       1   1 or 2
// PORTS
//   clock           in   1          system clock; all logic on rising edge
//   reset           in   1          asynchronous, active-high reset
//   incoming_bit    in   1          raw serial line, idle high, asynchronous to clock
//   data_ack        in   1          consumer accepts current word (effective only while has_data=1)
//   has_data        out  1          data_received and error flags are valid
//   data_received   out  DATA_BITS  received word
//   parity_error    out  1          parity mismatch for the held word (0 when PARITY_MODE=0)
//   framing_error   out  1          a stop bit was sampled 0 for the held word
//   overrun         out  1          a frame was dropped because the held word was not acked
//   is_receiving    out  1          high from start-bit detection until return to IDLE
// BEHAVIOUR
// - Reset: every output 0, FSM IDLE, counters 0, synchroniser flops 1. Reset mid-frame aborts
//   the frame immediately; no partial word is ever presented.
// - incoming_bit passes a 2-flop synchroniser; all decisions use the synchronised line.
// - FSM IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//   IDLE:   start on falling edge (previous synced sample 1, current 0). Line held low never
//           retriggers; a new start needs the line to return high first (break protection).
//   START:  wait (CLOCKS_PER_BIT-1)/2 cycles to mid-bit; line 0 -> DATA, line 1 -> IDLE (glitch).
//   DATA:   sample every CLOCKS_PER_BIT cycles at mid-bit, shift LSB first, DATA_BITS samples.
//   PARITY: skipped when PARITY_MODE=0. One sample; error if XOR(data,parity) mismatches mode.
//   STOP:   STOP_BITS samples; any 0 sets frame framing error. After the final stop sample
//           go to IDLE at once (half-bit early, allows back-to-back frames).
// - Frame complete: on the edge after the final stop sample the word is offered to the output
//   register; has_data rises that edge. Frames with errors are still delivered, flagged.
// - Handshake: has_data stays 1 and outputs stay stable until data_ack=1 while has_data=1; the
//   next edge clears has_data, parity_error, framing_error and overrun.
// - Overrun: frame completes while has_data=1 and no ack that cycle -> new frame discarded,
//   held word kept, overrun=1 (sticky until ack).
// - Simultaneous ack + completion: old word consumed, new word loaded, has_data stays 1,
//   overrun stays 0.
// - Bit counter width $clog2(DATA_BITS+1); cycle counter width $clog2(CLOCKS_PER_BIT); counters
//   reload to 0 on each bit, never wrap mid-bit.
// CONFIGURATION
//   UART_RX_MAJORITY_EN defined: every bit (start, data, parity, stop) is the 2-of-3 majority of
//     synced samples at mid-1, mid, mid+1; bit decision taken at mid+1 (all timing +1 cycle).
//   Not defined: single sample at mid; no extra registers.
// TESTING (10 MHz clock, CLOCKS_PER_BIT=87, defaults unless stated)
// 1. 8N1 frame 0x55 -> has_data=1 with data_received=0x55, all error flags 0; ack -> has_data=0.
// 2. PARITY_MODE=2, 0xA3 with parity bit 1 (correct 0) -> data 0xA3, parity_error=1; with
//    parity bit 0 -> parity_error=0.
// 3. Frame 0x0F, stop bit 0, line held low 20 bit times -> one word, framing_error=1, no further
//    has_data; line high, then 0x3C -> clean 0x3C.
// 4. Frames 0x11 then 0x22, no ack -> data stays 0x11, overrun=1 after second frame; ack ->
//    has_data=0, overrun=0. Repeat with ack on the completion cycle -> 0x22 held, overrun=0.
// 5. Line low 20 cycles then high -> no has_data, is_receiving back to 0 by cycle 45. Reset
//    pulsed mid-bit 4 of a frame -> all outputs 0; next 0xC3 received correctly.
// 6. 1-cycle high glitch at mid of data bit 2 of 0x00: macro defined -> 0x00; undefined -> 0x04.
//    DATA_BITS=9, STOP_BITS=2, 0x1A5 -> data 0x1A5, no errors.

Source files
------------

// File: rtl/uart_rx_framed.sv
// +----------------------------------------------------------------------------+
// | Module      : uart_rx_framed                                               |
// | Description : Parametrised UART receiver (5..9 data bits, none/odd/even    |
// |               parity, 1-2 stop bits) with error flags, overrun and a       |
// |               valid/ack output register. Optional UART_RX_MAJORITY_EN      |
// |               selects 2-of-3 majority bit sampling.                        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module uart_rx_framed #(
    parameter int CLOCKS_PER_BIT = 87,
    parameter int DATA_BITS      = 8,
    parameter int PARITY_MODE    = 0,
    parameter int STOP_BITS      = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 incoming_bit,
    input  logic                 data_ack,
    output logic                 has_data,
    output logic [DATA_BITS-1:0] data_received,
    output logic                 parity_error,
    output logic                 framing_error,
    output logic                 overrun,
    output logic                 is_receiving
);

    localparam int c_cnt_w    = $clog2(CLOCKS_PER_BIT);
    localparam int c_bit_w    = $clog2(DATA_BITS + 1);
    localparam bit c_par_en   = (PARITY_MODE != 0);
    localparam bit c_par_odd  = (PARITY_MODE == 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    logic sync1_q;
    logic sync2_q;
    logic line_prev_q;
    logic w_bit;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            line_prev_q <= 1'b1;
        end else begin
            sync1_q     <= incoming_bit;
            sync2_q     <= sync1_q;
            line_prev_q <= sync2_q;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    // Decision taken one cycle after mid-bit, once the mid+1 sample is present.
    localparam int c_maj_dly = 1;
    logic [1:0] hist_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hist_q <= 2'b11;
        end else begin
            hist_q <= {hist_q[0], sync2_q};
        end
    end

    assign w_bit = (hist_q[1] & hist_q[0]) | (hist_q[1] & sync2_q) | (hist_q[0] & sync2_q);
`else
    localparam int c_maj_dly = 0;
    assign w_bit = sync2_q;
`endif

    localparam logic [c_cnt_w-1:0] c_mid_cnt = c_cnt_w'((CLOCKS_PER_BIT - 1) / 2 - 1 + c_maj_dly);
    localparam logic [c_cnt_w-1:0] c_bit_end = c_cnt_w'(CLOCKS_PER_BIT - 1);
    localparam logic [c_bit_w-1:0] c_last_data = c_bit_w'(DATA_BITS - 1);
    localparam logic [c_bit_w-1:0] c_last_stop = c_bit_w'(STOP_BITS - 1);

    state_t                 state_q, state_d;
    logic [c_cnt_w-1:0]     cnt_q, cnt_d;
    logic [c_bit_w-1:0]     bitcnt_q, bitcnt_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   frame_pe_q, frame_pe_d;
    logic                   frame_fe_q, frame_fe_d;
    logic                   done_q, done_d;

    logic                   has_data_q, has_data_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   parity_err_q, parity_err_d;
    logic                   framing_err_q, framing_err_d;
    logic                   overrun_q, overrun_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            bitcnt_q      <= '0;
            shift_q       <= '0;
            frame_pe_q    <= 1'b0;
            frame_fe_q    <= 1'b0;
            done_q        <= 1'b0;
            has_data_q    <= 1'b0;
            data_q        <= '0;
            parity_err_q  <= 1'b0;
            framing_err_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            bitcnt_q      <= bitcnt_d;
            shift_q       <= shift_d;
            frame_pe_q    <= frame_pe_d;
            frame_fe_q    <= frame_fe_d;
            done_q        <= done_d;
            has_data_q    <= has_data_d;
            data_q        <= data_d;
            parity_err_q  <= parity_err_d;
            framing_err_q <= framing_err_d;
            overrun_q     <= overrun_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bitcnt_d   = bitcnt_q;
        shift_d    = shift_q;
        frame_pe_d = frame_pe_q;
        frame_fe_d = frame_fe_q;
        done_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d    = '0;
                bitcnt_d = '0;
                // A line stuck low has line_prev_q=0, so it can never retrigger.
                if (line_prev_q && !sync2_q) begin
                    state_d    = ST_START;
                    frame_pe_d = 1'b0;
                    frame_fe_d = 1'b0;
                end
            end
            ST_START: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == c_mid_cnt) begin
                    cnt_d   = '0;
                    state_d = w_bit ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == c_bit_end) begin
                    cnt_d   = '0;
                    shift_d = {w_bit, shift_q[DATA_BITS-1:1]};
                    if (bitcnt_q == c_last_data) begin
                        bitcnt_d = '0;
                        state_d  = c_par_en ? ST_PARITY : ST_STOP;
                    end else begin
                        bitcnt_d = bitcnt_q + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == c_bit_end) begin
                    cnt_d      = '0;
                    frame_pe_d = (((^shift_q) ^ w_bit) != c_par_odd);
                    state_d    = ST_STOP;
                end
            end
            ST_STOP: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == c_bit_end) begin
                    cnt_d = '0;
                    if (!w_bit) begin
                        frame_fe_d = 1'b1;
                    end
                    if (bitcnt_q == c_last_stop) begin
                        bitcnt_d = '0;
                        done_d   = 1'b1;
                        state_d  = ST_IDLE;
                    end else begin
                        bitcnt_d = bitcnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // An ack in the completion cycle frees the register for the new word.
    always_comb begin
        has_data_d    = has_data_q;
        data_d        = data_q;
        parity_err_d  = parity_err_q;
        framing_err_d = framing_err_q;
        overrun_d     = overrun_q;

        if (done_q) begin
            if (!has_data_q || data_ack) begin
                has_data_d    = 1'b1;
                data_d        = shift_q;
                parity_err_d  = frame_pe_q;
                framing_err_d = frame_fe_q;
                overrun_d     = 1'b0;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (has_data_q && data_ack) begin
            has_data_d    = 1'b0;
            parity_err_d  = 1'b0;
            framing_err_d = 1'b0;
            overrun_d     = 1'b0;
        end
    end

    assign has_data      = has_data_q;
    assign data_received = data_q;
    assign parity_error  = parity_err_q;
    assign framing_error = framing_err_q;
    assign overrun       = overrun_q;
    assign is_receiving  = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_framed.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_uart_rx_framed                                            |
// | Description : Directed, table-driven bench for uart_rx_framed (8N1, even   |
// |               parity, 9-bit/2-stop instances) plus multi-cycle sequences.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_uart_rx_framed;

    localparam int CPB = 87;
`ifdef UART_RX_MAJORITY_EN
    localparam int         MAJ        = 1;
    localparam logic [8:0] GLITCH_EXP = 9'h000;
`else
    localparam int         MAJ        = 0;
    localparam logic [8:0] GLITCH_EXP = 9'h004;
`endif

    logic       clock   = 1'b0;
    logic       reset   = 1'b1;
    logic [2:0] rx_line = 3'b111;
    logic [2:0] ack     = 3'b000;
    logic [2:0] hd, pe, fe, ov, ir;
    logic [7:0] data0, data1;
    logic [8:0] data2;

    int n_checks = 0;
    int n_errors = 0;

    always #50 clock = ~clock;

    uart_rx_framed #(.CLOCKS_PER_BIT(CPB)) u_dut8n1 (
        .clock(clock), .reset(reset), .incoming_bit(rx_line[0]), .data_ack(ack[0]),
        .has_data(hd[0]), .data_received(data0), .parity_error(pe[0]),
        .framing_error(fe[0]), .overrun(ov[0]), .is_receiving(ir[0])
    );

    uart_rx_framed #(.CLOCKS_PER_BIT(CPB), .PARITY_MODE(2)) u_dut_even (
        .clock(clock), .reset(reset), .incoming_bit(rx_line[1]), .data_ack(ack[1]),
        .has_data(hd[1]), .data_received(data1), .parity_error(pe[1]),
        .framing_error(fe[1]), .overrun(ov[1]), .is_receiving(ir[1])
    );

    uart_rx_framed #(.CLOCKS_PER_BIT(CPB), .DATA_BITS(9), .STOP_BITS(2)) u_dut9n2 (
        .clock(clock), .reset(reset), .incoming_bit(rx_line[2]), .data_ack(ack[2]),
        .has_data(hd[2]), .data_received(data2), .parity_error(pe[2]),
        .framing_error(fe[2]), .overrun(ov[2]), .is_receiving(ir[2])
    );

    typedef struct {
        int         sel;
        logic [8:0] data;
        int         nbits;
        bit         par_en;
        bit         par;
        logic [1:0] stops;
        int         nstop;
        logic [8:0] exp_data;
        bit         exp_pe;
        bit         exp_fe;
    } vec_t;

    vec_t vecs[11];

    function automatic logic [8:0] get_data(input int s);
        case (s)
            0:       return {1'b0, data0};
            1:       return {1'b0, data1};
            default: return data2;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_bit(input int s, input logic v);
        rx_line[s] = v;
        repeat (CPB) @(negedge clock);
    endtask

    // ack_at >= 0 pulses data_ack that many cycles into the final stop bit.
    task automatic send_frame(input int s, input logic [8:0] d, input int nb, input bit pen,
                              input bit pb, input logic [1:0] st, input int ns, input int ack_at);
        drive_bit(s, 1'b0);
        for (int i = 0; i < nb; i++) drive_bit(s, d[i]);
        if (pen) drive_bit(s, pb);
        for (int i = 0; i < ns; i++) begin
            if (i == ns - 1 && ack_at >= 0) begin
                rx_line[s] = st[i];
                repeat (ack_at) @(negedge clock);
                ack[s] = 1'b1;
                @(negedge clock);
                ack[s] = 1'b0;
                repeat (CPB - ack_at - 1) @(negedge clock);
            end else begin
                drive_bit(s, st[i]);
            end
        end
    endtask

    task automatic wait_hd(input int s, input string name);
        int k = 0;
        while (!hd[s] && k < 4 * CPB) begin
            @(negedge clock);
            k++;
        end
        check(name, 32'(hd[s]), 32'd1);
    endtask

    task automatic do_ack(input int s, input string name);
        @(negedge clock);
        ack[s] = 1'b1;
        @(negedge clock);
        ack[s] = 1'b0;
        check(name, 32'(hd[s]), 32'd0);
    endtask

    initial begin
        #(80000 * 100);
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int seen;

        vecs[0]  = '{0, 9'h055, 8, 0, 0, 2'b11, 1, 9'h055, 0, 0};
        vecs[1]  = '{0, 9'h080, 8, 0, 0, 2'b11, 1, 9'h080, 0, 0};
        vecs[2]  = '{0, 9'h0FF, 8, 0, 0, 2'b11, 1, 9'h0FF, 0, 0};
        vecs[3]  = '{0, 9'h03C, 8, 0, 0, 2'b10, 1, 9'h03C, 0, 1};
        vecs[4]  = '{1, 9'h0A3, 8, 1, 1, 2'b11, 1, 9'h0A3, 1, 0};
        vecs[5]  = '{1, 9'h0A3, 8, 1, 0, 2'b11, 1, 9'h0A3, 0, 0};
        vecs[6]  = '{1, 9'h001, 8, 1, 1, 2'b11, 1, 9'h001, 0, 0};
        vecs[7]  = '{1, 9'h001, 8, 1, 0, 2'b11, 1, 9'h001, 1, 0};
        vecs[8]  = '{2, 9'h1A5, 9, 0, 0, 2'b11, 2, 9'h1A5, 0, 0};
        vecs[9]  = '{2, 9'h0FF, 9, 0, 0, 2'b01, 2, 9'h0FF, 0, 1};
        vecs[10] = '{2, 9'h100, 9, 0, 0, 2'b10, 2, 9'h100, 0, 1};

        repeat (3) @(negedge clock);
        check("rst_hd",   32'(hd),       32'd0);
        check("rst_data", 32'(data0),    32'd0);
        check("rst_err",  32'(pe | fe),  32'd0);
        check("rst_ovr",  32'(ov),       32'd0);
        check("rst_recv", 32'(ir),       32'd0);
        reset = 1'b0;
        repeat (5) @(negedge clock);

        for (int i = 0; i < 11; i++) begin
            send_frame(vecs[i].sel, vecs[i].data, vecs[i].nbits, vecs[i].par_en, vecs[i].par,
                       vecs[i].stops, vecs[i].nstop, -1);
            rx_line[vecs[i].sel] = 1'b1;
            wait_hd(vecs[i].sel, $sformatf("v%0d_hd", i));
            check($sformatf("v%0d_data", i), 32'(get_data(vecs[i].sel)), 32'(vecs[i].exp_data));
            check($sformatf("v%0d_pe", i), 32'(pe[vecs[i].sel]), 32'(vecs[i].exp_pe));
            check($sformatf("v%0d_fe", i), 32'(fe[vecs[i].sel]), 32'(vecs[i].exp_fe));
            check($sformatf("v%0d_ovr", i), 32'(ov[vecs[i].sel]), 32'd0);
            do_ack(vecs[i].sel, $sformatf("v%0d_ack", i));
            repeat (4) @(negedge clock);
        end

        // Bad stop bit followed by a long break: exactly one word, then recovery.
        send_frame(0, 9'h00F, 8, 0, 0, 2'b00, 1, -1);
        wait_hd(0, "brk_hd");
        check("brk_data", 32'(data0), 32'h0F);
        check("brk_fe",   32'(fe[0]), 32'd1);
        do_ack(0, "brk_ack");
        seen = 0;
        for (int k = 0; k < 19 * CPB; k++) begin
            @(negedge clock);
            if (hd[0]) seen++;
        end
        check("brk_no_retrigger", 32'(seen), 32'd0);
        check("brk_idle", 32'(ir[0]), 32'd0);
        rx_line[0] = 1'b1;
        repeat (2 * CPB) @(negedge clock);
        send_frame(0, 9'h03C, 8, 0, 0, 2'b11, 1, -1);
        wait_hd(0, "rec_hd");
        check("rec_data", 32'(data0), 32'h3C);
        check("rec_err",  32'({pe[0], fe[0]}), 32'd0);
        do_ack(0, "rec_ack");

        // Overrun: second frame dropped while the first is still held.
        send_frame(0, 9'h011, 8, 0, 0, 2'b11, 1, -1);
        send_frame(0, 9'h022, 8, 0, 0, 2'b11, 1, -1);
        repeat (4) @(negedge clock);
        check("ovr_hd",   32'(hd[0]), 32'd1);
        check("ovr_data", 32'(data0), 32'h11);
        check("ovr_flag", 32'(ov[0]), 32'd1);
        do_ack(0, "ovr_ack");
        check("ovr_clear", 32'(ov[0]), 32'd0);
        repeat (4) @(negedge clock);

        // Ack lands on the completion cycle of the second frame.
        send_frame(0, 9'h011, 8, 0, 0, 2'b11, 1, -1);
        send_frame(0, 9'h022, 8, 0, 0, 2'b11, 1, 46 + MAJ);
        repeat (4) @(negedge clock);
        check("sim_hd",   32'(hd[0]), 32'd1);
        check("sim_data", 32'(data0), 32'h22);
        check("sim_ovr",  32'(ov[0]), 32'd0);
        do_ack(0, "sim_ack");
        repeat (4) @(negedge clock);

        // 20-cycle low pulse is a false start.
        rx_line[0] = 1'b0;
        repeat (10) @(negedge clock);
        check("glitch_start_recv", 32'(ir[0]), 32'd1);
        repeat (10) @(negedge clock);
        rx_line[0] = 1'b1;
        repeat (27) @(negedge clock);
        check("glitch_start_idle", 32'(ir[0]), 32'd0);
        check("glitch_start_hd",   32'(hd[0]), 32'd0);
        repeat (CPB) @(negedge clock);

        // Reset in the middle of data bit 4 while an older word is held.
        send_frame(0, 9'h05A, 8, 0, 0, 2'b11, 1, -1);
        wait_hd(0, "pre_rst_hd");
        drive_bit(0, 1'b0);
        for (int i = 0; i < 4; i++) drive_bit(0, (8'hC3 >> i) & 8'h01);
        rx_line[0] = 1'b0;
        repeat (43) @(negedge clock);
        reset = 1'b1;
        rx_line[0] = 1'b1;
        @(negedge clock);
        check("mrst_hd",   32'(hd[0]), 32'd0);
        check("mrst_data", 32'(data0), 32'd0);
        check("mrst_recv", 32'(ir[0]), 32'd0);
        reset = 1'b0;
        seen = 0;
        for (int k = 0; k < 2 * CPB; k++) begin
            @(negedge clock);
            if (hd[0] || ir[0]) seen++;
        end
        check("mrst_quiet", 32'(seen), 32'd0);
        send_frame(0, 9'h0C3, 8, 0, 0, 2'b11, 1, -1);
        wait_hd(0, "post_rst_hd");
        check("post_rst_data", 32'(data0), 32'hC3);
        do_ack(0, "post_rst_ack");
        repeat (4) @(negedge clock);

        // One-cycle high glitch exactly at mid of data bit 2 of 0x00.
        drive_bit(0, 1'b0);
        drive_bit(0, 1'b0);
        drive_bit(0, 1'b0);
        rx_line[0] = 1'b0;
        repeat (43) @(negedge clock);
        rx_line[0] = 1'b1;
        @(negedge clock);
        rx_line[0] = 1'b0;
        repeat (43) @(negedge clock);
        for (int i = 0; i < 5; i++) drive_bit(0, 1'b0);
        drive_bit(0, 1'b1);
        wait_hd(0, "gl_hd");
        check("gl_data", 32'(data0), 32'(GLITCH_EXP));
        check("gl_fe",   32'(fe[0]), 32'd0);
        do_ack(0, "gl_ack");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
